// File: rtl/seg_scan_display_pkg.sv
// rtl/seg_scan_display_pkg.sv - segment pattern constants for the multiplexed display
package seg_scan_display_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All digit enables released (active-low)
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seg_scan_display_bcd_to_7seg.sv
// rtl/seg_scan_display_bcd_to_7seg.sv - 7-bit value to active-low segment pattern
module bcd_to_7seg
    import seg_scan_display_pkg::*;
(
    input  logic [6:0] i_val,
    output logic [6:0] o_seg
);

    // Anything outside 0..9, including nonzero upper bits, shows a dash
    always_comb begin
        o_seg = SEG_DASH;
        case (i_val)
            7'd0:    o_seg = SEG_0;
            7'd1:    o_seg = SEG_1;
            7'd2:    o_seg = SEG_2;
            7'd3:    o_seg = SEG_3;
            7'd4:    o_seg = SEG_4;
            7'd5:    o_seg = SEG_5;
            7'd6:    o_seg = SEG_6;
            7'd7:    o_seg = SEG_7;
            7'd8:    o_seg = SEG_8;
            7'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - MM:SS 4-digit multiplexed 7-segment scanner with frame snapshot
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter int LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] one_second,
    input  logic [6:0] ten_second,
    input  logic [6:0] one_minute,
    input  logic [6:0] ten_minute,
    input  logic       stop,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [6:0]    r_sh_s, r_sh_ts, r_sh_m, r_sh_tm;
    logic          r_sh_stop;

    logic          w_tick;
    logic          w_frame;
    logic [6:0]    w_digit;
    logic [6:0]    w_pat;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;
    logic          w_dp_nxt;

    assign w_tick  = (r_presc == PW'(SCAN_DIV - 1));
    // The slot-3 tick closes a frame: the last digit still shows old shadows
    assign w_frame = w_tick && (r_idx == 2'd3);

    // Refresh prescaler, one tick per digit slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // Digit index walks 0..3 on each tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_idx <= 2'd0;
        else if (w_tick) r_idx <= r_idx + 2'd1;
    end

    // Shadow registers reload only at frame boundaries so a frame never tears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_s    <= '0;
            r_sh_ts   <= '0;
            r_sh_m    <= '0;
            r_sh_tm   <= '0;
            r_sh_stop <= 1'b0;
        end else if (w_frame) begin
            r_sh_s    <= one_second;
            r_sh_ts   <= ten_second;
            r_sh_m    <= one_minute;
            r_sh_tm   <= ten_minute;
            r_sh_stop <= stop;
        end
    end

    // Frame counter drives the blink phase for colon and adjust blinking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame) begin
            if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Select the shadow digit for the slot being presented
    always_comb begin
        w_digit = r_sh_s;
        case (r_idx)
            2'd0: w_digit = r_sh_s;
            2'd1: w_digit = r_sh_ts;
            2'd2: w_digit = r_sh_m;
            2'd3: w_digit = r_sh_tm;
            default: w_digit = r_sh_s;
        endcase
    end

    bcd_to_7seg u_dec (
        .i_val (w_digit),
        .o_seg (w_pat)
    );

    // Next pin values: decoded digit with adjust-blink and leading-zero blanking
    always_comb begin
        w_seg_nxt = w_pat;
        w_an_nxt  = ~(4'b0001 << r_idx);
        w_dp_nxt  = 1'b1;
        if ((r_idx == 2'd0 || r_idx == 2'd1) && r_sh_stop && !r_blink_phase)
            w_seg_nxt = SEG_BLANK;
        if ((r_idx == 2'd3) && (LZ_BLANK != 0) && (r_sh_tm == 7'd0))
            w_seg_nxt = SEG_BLANK;
        if ((r_idx == 2'd2) && r_blink_phase)
            w_dp_nxt  = 1'b0;
    end

    // Pins update on each tick; dark from reset until the first tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= AN_OFF;
        end else if (w_tick) begin
            seg <= w_seg_nxt;
            dp  <= w_dp_nxt;
            an  <= w_an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] one_second, ten_second, one_minute, ten_minute;
    logic       stop;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks = 0;
    int n_errors = 0;
    int frame_no = 0;

    logic [11:0] sb_q[$];
    logic [3:0]  last_an = 4'hF;

    always #5 clk = ~clk;

    seg_scan_display #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .one_second (one_second),
        .ten_second (ten_second),
        .one_minute (one_minute),
        .ten_minute (ten_minute),
        .stop       (stop),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_dec(input logic [6:0] v);
        case (v)
            7'd0: return 7'h40;
            7'd1: return 7'h79;
            7'd2: return 7'h24;
            7'd3: return 7'h30;
            7'd4: return 7'h19;
            7'd5: return 7'h12;
            7'd6: return 7'h02;
            7'd7: return 7'h78;
            7'd8: return 7'h00;
            7'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Four expected slots {an,seg,dp} of one frame built from the snapshot values
    task automatic push_frame(input logic [6:0] s, ts, m, tm, input logic st, input int fno);
        logic       phase;
        logic [3:0] a;
        logic [6:0] sg;
        logic       d;
        logic [6:0] v;
        phase = ((fno / 2) % 2) == 1;
        for (int k = 0; k < 4; k++) begin
            a = 4'hF;
            a[k] = 1'b0;
            v = (k == 0) ? s : (k == 1) ? ts : (k == 2) ? m : tm;
            sg = ref_dec(v);
            if (k < 2 && st && !phase) sg = 7'h7F;
            if (k == 3 && tm == 7'd0)  sg = 7'h7F;
            d = !(k == 2 && phase);
            sb_q.push_back({a, sg, d});
        end
    endtask

    // Drive the values the next frame boundary will latch, then run one frame
    task automatic run_frame(input logic [6:0] s, ts, m, tm, input logic st);
        frame_no++;
        one_second = s;
        ten_second = ts;
        one_minute = m;
        ten_minute = tm;
        stop       = st;
        push_frame(s, ts, m, tm, st, frame_no);
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb_q.delete();
        #1;
        check_val("rst_seg", {25'd0, seg}, 32'h7F);
        check_val("rst_dp",  {31'd0, dp},  32'h1);
        check_val("rst_an",  {28'd0, an},  32'hF);
        repeat (3) @(negedge clk);
        frame_no = 0;
        push_frame(7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_dark", {28'd0, an}, 32'hF);
    endtask

    // Compare each new lit slot against the head of the scoreboard
    always @(negedge clk) begin
        if (rst && an != last_an && an != 4'hF) begin
            check_val("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'h1);
            if (sb_q.size() > 0)
                check_val("slot", {20'd0, an, seg, dp}, {20'd0, sb_q.pop_front()});
        end
        last_an = an;
    end

    initial begin
        rst = 1'b1;
        {one_second, ten_second, one_minute, ten_minute} = '0;
        stop = 1'b0;
        #2;
        do_reset();
        fork
            begin
                @(posedge clk); #1 check_val("dark_edge2", {28'd0, an}, 32'hF);
                @(posedge clk); #1 check_val("dark_edge3", {28'd0, an}, 32'hF);
                @(posedge clk); #1 check_val("first_tick", {28'd0, an}, 32'hE);
            end
        join_none

        run_frame(7'd1, 7'd2, 7'd3, 7'd4, 1'b0);
        run_frame(7'd1, 7'd2, 7'd3, 7'd4, 1'b0);
        run_frame(7'd1, 7'd2, 7'd3, 7'd4, 1'b0);
        run_frame(7'd5, 7'd2, 7'd3, 7'd4, 1'b0);
        run_frame(7'd6, 7'd2, 7'd3, 7'd4, 1'b0);
        run_frame(7'h0C, 7'd2, 7'd3, 7'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_frame(7'd7, 7'd5, 7'd9, 7'd5, 1'b1);
        run_frame(7'h15, 7'd9, 7'd8, 7'd2, 1'b0);

        // Mid-scan reset while slot 2 is lit
        repeat (12) @(posedge clk);
        #2;
        check_val("pre_rst_slot2", {28'd0, an}, 32'hB);
        do_reset();
        run_frame(7'd8, 7'd9, 7'd0, 7'd1, 1'b0);
        run_frame(7'd8, 7'd9, 7'd0, 7'd1, 1'b0);

        repeat (16) @(posedge clk);
        #1;
        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
